// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with registered read data, occupancy count,
// almost-full/almost-empty thresholds and sticky overflow/underflow flags.
module sync_fifo_param #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int AFULL_TH  = DEPTH - 2,
    parameter int AEMPTY_TH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           in,
    input  logic                       rd_en,
    input  logic                       clr_err,
    output logic [WIDTH-1:0]           out,
    output logic                       empty,
    output logic                       full,
    output logic                       almost_empty,
    output logic                       almost_full,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] C_DEPTH  = (AW+1)'(DEPTH);
    localparam logic [AW:0] C_AFULL  = (AW+1)'(AFULL_TH);
    localparam logic [AW:0] C_AEMPTY = (AW+1)'(AEMPTY_TH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic [WIDTH-1:0] r_out;
    logic             r_overflow;
    logic             r_underflow;

    logic w_empty;
    logic w_full;
    logic w_rd_acc;
    logic w_wr_acc;

    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == C_DEPTH);
    assign w_rd_acc = rd_en & ~w_empty;
    // At full a same-cycle read frees the slot being written; at empty no bypass.
    assign w_wr_acc = wr_en & (~w_full | rd_en);

    // Storage kept free of reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_out       <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_out    <= r_mem[r_rd_ptr];
            end
            r_count <= r_count + (AW+1)'(w_wr_acc) - (AW+1)'(w_rd_acc);
            // A new rejection in the same cycle wins over clr_err.
            r_overflow  <= (wr_en & ~w_wr_acc) | (r_overflow  & ~clr_err);
            r_underflow <= (rd_en & ~w_rd_acc) | (r_underflow & ~clr_err);
        end
    end

    assign out          = r_out;
    assign empty        = w_empty;
    assign full         = w_full;
    assign almost_empty = (r_count <= C_AEMPTY);
    assign almost_full  = (r_count >= C_AFULL);
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;
endmodule

// File: tb/tb_sync_fifo_param.sv
// Randomised scoreboard bench for sync_fifo_param: a queue-based reference model
// predicts read data and status; a negedge monitor checks the registered output.
module tb_sync_fifo_param;
    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int AFT   = 14;
    localparam int AET   = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             wr_en = 1'b0;
    logic [WIDTH-1:0] in = '0;
    logic             rd_en = 1'b0;
    logic             clr_err = 1'b0;
    logic [WIDTH-1:0] out;
    logic             empty, full, almost_empty, almost_full, overflow, underflow;
    logic [4:0]       count;

    int total = 0;
    int bad   = 0;

    logic [WIDTH-1:0] model_q[$];
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] hold_val = '0;
    bit               mon_go = 1'b0;
    bit               m_ovf = 1'b0;
    bit               m_udf = 1'b0;

    sync_fifo_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AFULL_TH(AFT), .AEMPTY_TH(AET)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .in(in), .rd_en(rd_en), .clr_err(clr_err),
        .out(out), .empty(empty), .full(full), .almost_empty(almost_empty),
        .almost_full(almost_full), .count(count), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_status(input string tag);
        int n;
        n = model_q.size();
        chk({tag, ".count"}, int'(count), n);
        chk({tag, ".empty"}, int'(empty), int'(n == 0));
        chk({tag, ".full"}, int'(full), int'(n == DEPTH));
        chk({tag, ".almost_empty"}, int'(almost_empty), int'(n <= AET));
        chk({tag, ".almost_full"}, int'(almost_full), int'(n >= AFT));
        chk({tag, ".overflow"}, int'(overflow), int'(m_ovf));
        chk({tag, ".underflow"}, int'(underflow), int'(m_udf));
    endtask

    // Monitor: whenever a read was accepted, out must show the oldest queued word;
    // otherwise it must still hold the previous value.
    always @(negedge clk) begin
        if (mon_go) begin
            mon_go = 1'b0;
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL read_data: got=%0h expected=<nothing queued>", out);
            end else begin
                hold_val = exp_q.pop_front();
                chk("read_data", int'(out), int'(hold_val));
                $display("read: out=%02h", out);
            end
        end else if (!rst) begin
            chk("out_hold", int'(out), int'(hold_val));
        end
    end

    // One clock of stimulus; the model applies the accept rules to its own occupancy.
    task automatic step(input bit w, input logic [WIDTH-1:0] d, input bit r, input bit c);
        bit ra, wa;
        wr_en = w; in = d; rd_en = r; clr_err = c;
        ra = r && (model_q.size() > 0);
        wa = w && ((model_q.size() < DEPTH) || r);
        @(posedge clk);
        if (ra) begin
            exp_q.push_back(model_q.pop_front());
            mon_go = 1'b1;
        end
        if (wa) model_q.push_back(d);
        m_ovf = (w && !wa) || (m_ovf && !c);
        m_udf = (r && !ra) || (m_udf && !c);
        #1;
        $display("op: wr=%0b in=%02h rd=%0b clr=%0b -> count=%0d ovf=%0b udf=%0b",
                 w, d, r, c, count, overflow, underflow);
        chk_status("step");
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst.out", int'(out), 0);
        chk_status("rst");
        @(posedge clk); #1; rst = 1'b0;

        // Fill to full, overflow, drain
        for (int i = 1; i <= 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        step(1'b1, 8'hAA, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1);

        // Simultaneous read/write at full
        for (int i = 1; i <= 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        step(1'b1, 8'h55, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

        // Simultaneous read/write at empty: write only, underflow
        step(1'b1, 8'h33, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        // clr_err alone clears; with a concurrent rejected read underflow remains
        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b1);

        // Pointer wrap with occupancy 0..5
        for (int i = 0; i < 80; i++) begin
            if (model_q.size() == 0 || (model_q.size() < 5 && $urandom_range(0, 1) == 1))
                step(1'b1, 8'($urandom), 1'b0, 1'b0);
            else
                step(1'b0, 8'h00, 1'b1, 1'b0);
        end
        while (model_q.size() > 0) step(1'b0, 8'h00, 1'b1, 1'b0);

        // Asynchronous reset mid-burst at count 7
        for (int i = 0; i < 7; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b1, 8'hC7, 1'b0, 1'b0);
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        model_q.delete(); exp_q.delete();
        mon_go = 1'b0; hold_val = '0; m_ovf = 1'b0; m_udf = 1'b0;
        chk("async_rst.out", int'(out), 0);
        chk_status("async_rst");
        @(posedge clk); #1; rst = 1'b0;
        step(1'b1, 8'h77, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        // Random traffic across the full range, including error clears
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 99) < 55), 8'($urandom), 1'($urandom_range(0, 99) < 45),
                 1'($urandom_range(0, 99) < 5));
        step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
